sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one sram-like memory port between two requesters: the instruction-fetch port (m0) and the data port (m1).
- Both requesters use the split req/addr_ok/data_ok handshake. The block sits between the pipeline (fetch stage, execute-stage data SRAM interface) and the single memory/bridge port.
- Default priority is data over fetch, with an anti-starvation counter. Grant is locked while a request waits for addr_ok.
- Responses return in order. An owner FIFO routes each data_ok/rdata back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, max accepted-but-unanswered requests; owner FIFO depth (power of 2, >=1)
- STARVE_LIMIT, 4, consecutive data-port handshakes allowed while fetch is waiting before fetch is forced ahead

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  fetch request valid
- m0_wr  in  1  fetch write (normally 0)
- m0_size  in  2  0=byte, 1=half, 2=word
- m0_wstrb  in  4  byte write strobes
- m0_addr  in  32  fetch address
- m0_wdata  in  32  fetch write data
- m0_addr_ok  out  1  fetch request accepted
- m0_data_ok  out  1  fetch response valid
- m1_req, m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata  in  1/1/2/4/32/32  data-port request, same meaning as m0
- m1_addr_ok  out  1  data request accepted
- m1_data_ok  out  1  data response valid
- m_rdata  out  32  response data, shared by both requesters
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/4/32/32  request forwarded to the memory port
- s_addr_ok  in  1  memory accepted request
- s_data_ok  in  1  memory response valid
- s_rdata  in  32  memory read data
- err_stray  out  1  one-cycle pulse: s_data_ok arrived with no outstanding request

Behaviour:
- Reset: state IDLE, owner FIFO empty (count 0, pointers 0), starve counter 0. All outputs 0 (they are combinational from state and inputs, and every enable is gated).
- States:
  - IDLE: no request pending.
  - LOCK0 / LOCK1: m0 / m1 was presented to the memory and has not yet received s_addr_ok.
- Grant in IDLE:
  - Arbitration is allowed only if count < MAX_OUTSTANDING. When full, no grant: s_req=0 and both addr_ok=0.
  - No same-cycle bypass on pop.
  - Winner is m1 if m1_req && !(m0_req && starve==STARVE_LIMIT); otherwise m0 if m0_req.
- Grant in LOCKx: always x; the FIFO-full check is not applied.
- Forwarding:
  - s_req = granted requester's req.
  - s_wr/s_size/s_wstrb/s_addr/s_wdata are muxed from the granted requester; all zero when nothing is granted.
  - mx_addr_ok = grant==x && s_addr_ok. This is combinational, zero-latency.
- Transitions:
  - IDLE: grant x with s_addr_ok=0 -> LOCKx.
  - IDLE: grant x with s_addr_ok=1 -> stay IDLE.
  - LOCKx: s_addr_ok=1 -> IDLE; otherwise stay in LOCKx. A higher-priority request arriving meanwhile does not steal the grant.
- Owner FIFO:
  - Push requester id (0/1) on every s_req && s_addr_ok.
  - Pop on s_data_ok when count>0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING+1).
- Response routing:
  - mx_data_ok = s_data_ok && count>0 && head==x.
  - m_rdata = s_rdata unconditionally.
  - s_data_ok with count==0: err_stray=1 for that cycle; no master data_ok; FIFO unchanged.
- Starve counter (saturating at STARVE_LIMIT):
  - +1 on each m1 handshake while m0_req=1.
  - Cleared on each m0 handshake, or when m0_req=0.
- Reset mid-operation: lock and FIFO are dropped. Subsequent memory responses to pre-reset requests appear as stray and are reported on err_stray.

Test Plan:
- Single fetch: m0_req, m0_addr=0x1c000000, s_addr_ok=1 at cycle 0; s_data_ok at cycle 2 with s_rdata=0x12345678 -> m0_addr_ok=1 at cycle 0; m0_data_ok=1 with m_rdata=0x12345678 at cycle 2; m1_data_ok stays 0.
- Contention: m0_req and m1_req both high, s_addr_ok tied 1 -> cycle 0 s_addr=m1_addr and m1_addr_ok=1; cycle 1 (m1_req dropped) s_addr=m0_addr and m0_addr_ok=1; FIFO order is 1,0; the two data_ok pulses route to m1 then m0.
- Lock: m0_req alone, s_addr_ok held 0 for cycles 0-2; m1_req rises at cycle 1 -> s_addr stays m0_addr through cycle 3 (s_addr_ok=1); m1 granted at cycle 4.
- Full: MAX_OUTSTANDING=2, two requests accepted with no data_ok, third m1_req -> s_req=0, m1_addr_ok=0; one s_data_ok pops -> third request accepted the following cycle.
- Starvation: STARVE_LIMIT=4, m0_req and m1_req held high, s_addr_ok=1 -> four m1 handshakes, the fifth goes to m0, then the counter resets to 0.
- Stray/reset: s_data_ok with empty FIFO -> err_stray pulse, no mx_data_ok. Assert reset while in LOCK1 with count=1 -> next cycle state IDLE, count 0, s_req follows the new arbitration.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like memory port between the fetch port
// (m0) and the data port (m1).
// Data requests normally win. A starvation counter forces fetch ahead after
// STARVE_LIMIT data handshakes that happened while fetch was waiting.
// A request that has been presented but not yet accepted keeps the grant
// until it is accepted.
// Responses come back in order. An owner FIFO remembers which requester
// issued each accepted request, so each response is routed to that requester.
//
// state | meaning
// IDLE  | no request held; arbitrate this cycle
// LOCK0 | m0 presented to memory, waiting for s_addr_ok
// LOCK1 | m1 presented to memory, waiting for s_addr_ok
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        err_stray
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [SW-1:0]              starve_q, starve_d;

    logic gnt_vld;
    logic gnt_id;
    logic push;
    logic pop;
    logic fifo_nempty;
    logic head_id;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Grant selection. A held grant bypasses the full check, because the
    // FIFO had room when that request was first presented.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q < CNT_MAX) begin
                    if (m1_req && !(m0_req && starve_q == STARVE_MAX)) begin
                        gnt_vld = 1'b1;
                        gnt_id  = 1'b1;
                    end else if (m0_req) begin
                        gnt_vld = 1'b1;
                    end
                end
            end
            LOCK0: begin
                gnt_vld = 1'b1;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
            default: begin
                gnt_vld = 1'b0;
            end
        endcase
    end

    // Forward the granted requester's request fields; all zero when idle.
    always_comb begin
        s_req   = 1'b0;
        s_wr    = 1'b0;
        s_size  = 2'd0;
        s_wstrb = 4'd0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        if (gnt_vld) begin
            if (gnt_id) begin
                s_req   = m1_req;
                s_wr    = m1_wr;
                s_size  = m1_size;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_req   = m0_req;
                s_wr    = m0_wr;
                s_size  = m0_size;
                s_wstrb = m0_wstrb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
    end

    assign m0_addr_ok = s_req && s_addr_ok && !gnt_id;
    assign m1_addr_ok = s_req && s_addr_ok &&  gnt_id;

    assign push        = s_req && s_addr_ok;
    assign fifo_nempty = (count_q != '0);
    assign pop         = s_data_ok && fifo_nempty;
    assign head_id     = owner_q[rd_ptr_q];

    assign m0_data_ok = pop && !head_id;
    assign m1_data_ok = pop &&  head_id;
    assign m_rdata    = s_rdata;
    assign err_stray  = s_data_ok && !fifo_nempty;

    // Next state: hold the lock until the memory accepts the request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld && !s_addr_ok) begin
                    state_d = gnt_id ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (s_addr_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner FIFO pointers and occupancy; simultaneous push and pop keeps count.
    always_comb begin
        wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Starvation counter: counts data handshakes while fetch waits, saturating.
    always_comb begin
        starve_d = starve_q;
        if (!m0_req || m0_addr_ok) begin
            starve_d = '0;
        end else if (m1_addr_ok && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State, FIFO and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (push) begin
                owner_q[wr_ptr_q] <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter. A table of per-cycle vectors gives the
// inputs and the expected grant. A queue of expected response owners checks
// the data_ok routing and the stray-response flag.
module tb_sram_req_arbiter;

    localparam logic [31:0] M0_ADDR  = 32'h1c000000;
    localparam logic [31:0] M0_WDATA = 32'h00000000;
    localparam logic        M0_WR    = 1'b0;
    localparam logic [1:0]  M0_SIZE  = 2'd2;
    localparam logic [3:0]  M0_WSTRB = 4'h0;
    localparam logic [31:0] M1_ADDR  = 32'h80001000;
    localparam logic [31:0] M1_WDATA = 32'hcafef00d;
    localparam logic        M1_WR    = 1'b1;
    localparam logic [1:0]  M1_SIZE  = 2'd1;
    localparam logic [3:0]  M1_WSTRB = 4'hc;

    localparam logic [1:0] GN = 2'd0;
    localparam logic [1:0] G0 = 2'd1;
    localparam logic [1:0] G1 = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic        m0_wr, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err_stray;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        m0_req;
        logic        m1_req;
        logic        s_aok;
        logic        s_dok;
        logic [31:0] rdata;
        logic [1:0]  gnt;
    } vec_t;

    vec_t vecs[$];
    bit   sb[$];

    sram_req_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r0, input logic r1, input logic aok,
                                input logic dok, input logic [31:0] rd,
                                input logic [1:0] g);
        vec_t v;
        v.m0_req = r0;
        v.m1_req = r1;
        v.s_aok  = aok;
        v.s_dok  = dok;
        v.rdata  = rd;
        v.gnt    = g;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic        e_req, e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
        bit          owner;
        m0_req    = v.m0_req;
        m1_req    = v.m1_req;
        s_addr_ok = v.s_aok;
        s_data_ok = v.s_dok;
        s_rdata   = v.rdata;
        @(negedge clk);
        e_req = (v.gnt != GN);
        case (v.gnt)
            G0: begin
                e_wr = M0_WR; e_size = M0_SIZE; e_wstrb = M0_WSTRB;
                e_addr = M0_ADDR; e_wdata = M0_WDATA;
            end
            G1: begin
                e_wr = M1_WR; e_size = M1_SIZE; e_wstrb = M1_WSTRB;
                e_addr = M1_ADDR; e_wdata = M1_WDATA;
            end
            default: begin
                e_wr = 1'b0; e_size = 2'd0; e_wstrb = 4'd0;
                e_addr = 32'd0; e_wdata = 32'd0;
            end
        endcase
        chk("s_req", idx, 32'(s_req), 32'(e_req));
        chk("s_addr", idx, s_addr, e_addr);
        chk("s_wdata", idx, s_wdata, e_wdata);
        chk("s_wr_size_wstrb", idx, {25'd0, s_wr, s_size, s_wstrb},
            {25'd0, e_wr, e_size, e_wstrb});
        chk("m0_addr_ok", idx, 32'(m0_addr_ok), 32'(v.gnt == G0 && v.s_aok));
        chk("m1_addr_ok", idx, 32'(m1_addr_ok), 32'(v.gnt == G1 && v.s_aok));
        if (v.s_dok && sb.size() > 0) begin
            owner = sb.pop_front();
            chk("m0_data_ok", idx, 32'(m0_data_ok), 32'(!owner));
            chk("m1_data_ok", idx, 32'(m1_data_ok), 32'(owner));
            chk("m_rdata", idx, m_rdata, v.rdata);
            chk("err_stray", idx, 32'(err_stray), 32'd0);
        end else begin
            chk("m0_data_ok", idx, 32'(m0_data_ok), 32'd0);
            chk("m1_data_ok", idx, 32'(m1_data_ok), 32'd0);
            chk("err_stray", idx, 32'(err_stray), 32'(v.s_dok));
        end
        if (v.gnt != GN && v.s_aok) begin
            sb.push_back(v.gnt == G1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset     = 1'b1;
        m0_req    = 1'b0;
        m1_req    = 1'b0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = 32'd0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        m0_wr = M0_WR; m0_size = M0_SIZE; m0_wstrb = M0_WSTRB;
        m0_addr = M0_ADDR; m0_wdata = M0_WDATA;
        m1_wr = M1_WR; m1_size = M1_SIZE; m1_wstrb = M1_WSTRB;
        m1_addr = M1_ADDR; m1_wdata = M1_WDATA;

        // reset state
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        GN));
        // single fetch, response two cycles later, then a stray response
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        G0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        GN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h12345678, GN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h5a5a5a5a, GN));
        // contention: data first, then fetch; responses route in order
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        G1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        G0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h11111111, GN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h22222222, GN));
        // lock: fetch held while data arrives, data granted after acceptance
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        G0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        G0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        G0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        G0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        G1));
        // full: no grant until a pop has been registered
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        GN));
        vecs.push_back(mk(0, 1, 1, 1, 32'h33333333, GN));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        G1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h44444444, GN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h55555555, GN));
        // starvation: four data handshakes, then fetch, then data again
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        G1));
        vecs.push_back(mk(1, 1, 1, 1, 32'h60000001, G1));
        vecs.push_back(mk(1, 1, 1, 1, 32'h60000002, G1));
        vecs.push_back(mk(1, 1, 1, 1, 32'h60000003, G1));
        vecs.push_back(mk(1, 1, 1, 1, 32'h60000004, G0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h60000005, G1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h60000006, GN));

        apply_reset(2);
        foreach (vecs[i]) begin
            step(vecs[i], i);
        end

        // reset while LOCK1 with one request outstanding
        step(mk(1, 0, 1, 0, 32'h0, G0), 100);
        step(mk(0, 1, 0, 0, 32'h0, G1), 101);
        apply_reset(1);
        step(mk(1, 0, 0, 1, 32'h77777777, G0), 102);
        step(mk(1, 0, 1, 0, 32'h0,        G0), 103);
        step(mk(0, 0, 0, 1, 32'h88888888, GN), 104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
